// File: rtl/avr_bus_pkg.sv
// Shared types and the default C4 memory map for the AVR data-bus router.
package avr_bus_pkg;

  localparam int unsigned MAXCH = 8;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [15:0] base;
    logic [15:0] size;
  } win_t;

  localparam win_t VRAM_WIN  = '{base: 16'hB000, size: 16'h2000};
  localparam win_t CRAM_WIN  = '{base: 16'h0000, size: 16'h1000};
  localparam win_t STACK_WIN = '{base: 16'h1000, size: 16'h0800};

  // Channel 0 is the least significant slice
  localparam logic [47:0] DEF_BASE = {STACK_WIN.base, CRAM_WIN.base, VRAM_WIN.base};
  localparam logic [47:0] DEF_SIZE = {STACK_WIN.size, CRAM_WIN.size, VRAM_WIN.size};

endpackage

// File: rtl/avr_bus_decode.sv
// Combinational priority window decoder: one-hot hit, lowest index wins.
module avr_bus_decode
  import avr_bus_pkg::*;
#(
  parameter int unsigned            CHANNELS = 3,
  parameter int unsigned            AW       = 16,
  parameter logic [AW*CHANNELS-1:0] BASE     = DEF_BASE,
  parameter logic [AW*CHANNELS-1:0] SIZE     = DEF_SIZE
) (
  input  logic [AW-1:0]       addr_i,
  output logic [CHANNELS-1:0] hit_o,
  output logic                hit_v_o
);

  localparam int unsigned NCH = (CHANNELS > MAXCH) ? MAXCH : CHANNELS;

  logic [AW:0] lo;
  logic [AW:0] hi;

  // Compare in AW+1 bits so a window may end exactly at 2^AW
  always_comb begin
    hit_o   = '0;
    hit_v_o = 1'b0;
    lo      = '0;
    hi      = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      lo = {1'b0, BASE[k*AW +: AW]};
      hi = lo + {1'b0, SIZE[k*AW +: AW]};
      if (!hit_v_o && ({1'b0, addr_i} >= lo) && ({1'b0, addr_i} < hi)) begin
        hit_o[k] = 1'b1;
        hit_v_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/avr_bus_router.sv
// AVR data-bus router: window decode, per-channel wait states, read-return mux
// and a sticky capture of the first unmapped access.
module avr_bus_router
  import avr_bus_pkg::*;
#(
  parameter int unsigned             CHANNELS = 3,
  parameter int unsigned             AW       = 16,
  parameter int unsigned             DW       = 8,
  parameter logic [AW*CHANNELS-1:0]  BASE     = DEF_BASE,
  parameter logic [AW*CHANNELS-1:0]  SIZE     = DEF_SIZE,
  parameter logic [4*CHANNELS-1:0]   WAIT     = '0,
  parameter logic [CHANNELS-1:0]     REG_Q    = '0,
  parameter logic [DW-1:0]           FILL     = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [AW-1:0]          address,
  input  logic [DW-1:0]          data_o,
  input  logic                   we,
  input  logic                   read,
  output logic [DW-1:0]          data_i,
  output logic                   ce,
  output logic [AW*CHANNELS-1:0] ch_a,
  output logic [DW-1:0]          ch_d,
  output logic [CHANNELS-1:0]    ch_w,
  output logic [CHANNELS-1:0]    ch_r,
  input  logic [DW*CHANNELS-1:0] ch_q,
  output logic                   err,
  output logic [AW-1:0]          err_addr,
  input  logic                   err_clr
);

  logic [CHANNELS-1:0] hit, act_q, act_d, sel_q, sel_d, ch_w_c, ch_r_c;
  logic                hit_v, access, wr_q, wr_d, hit_regq, ce_c, unmapped;
  logic [CNT_W-1:0]    hit_wait, cnt_q, cnt_d;
  logic [DW-1:0]       hit_data, sel_data;
  state_t              state_q, state_d;
  logic                err_q, err_d;
  logic [AW-1:0]       err_addr_q, err_addr_d;

  avr_bus_decode #(
    .CHANNELS (CHANNELS),
    .AW       (AW),
    .BASE     (BASE),
    .SIZE     (SIZE)
  ) u_decode (
    .addr_i  (address),
    .hit_o   (hit),
    .hit_v_o (hit_v)
  );

  for (genvar k = 0; k < CHANNELS; k++) begin : g_off
    assign ch_a[k*AW +: AW] = address - BASE[k*AW +: AW];
  end

  // Per-channel attributes of the current hit and the registered read source
  always_comb begin
    hit_wait = '0;
    hit_regq = 1'b0;
    hit_data = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (hit[k]) begin
        hit_wait = WAIT[k*4 +: 4];
        hit_regq = REG_Q[k];
        hit_data = ch_q[k*DW +: DW];
      end
      if (sel_q[k]) begin
        sel_data = ch_q[k*DW +: DW];
      end
    end
  end

  // Next state and strobes; the access completes in the cycle ce is high
  always_comb begin
    access   = we | read;
    state_d  = state_q;
    cnt_d    = cnt_q;
    act_d    = act_q;
    wr_d     = wr_q;
    sel_d    = '0;
    ce_c     = 1'b0;
    ch_w_c   = '0;
    ch_r_c   = '0;
    unmapped = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          ce_c = 1'b1;
          if (access && !hit_v) begin
            unmapped = 1'b1;
          end else if (access && (hit_wait == '0)) begin
            ch_w_c = we ? hit : '0;
            ch_r_c = we ? '0 : hit;
            sel_d  = hit & REG_Q;
          end else if (access) begin
            ce_c    = 1'b0;
            cnt_d   = hit_wait - CNT_W'(1);
            act_d   = hit;
            wr_d    = we;
            ch_r_c  = we ? '0 : hit;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          ch_r_c = wr_q ? '0 : act_q;
          if (cnt_q == '0) begin
            ce_c    = 1'b1;
            ch_w_c  = wr_q ? act_q : '0;
            sel_d   = act_q & REG_Q;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A registered-return channel completed last cycle takes precedence
  always_comb begin
    data_i = FILL;
    if (!reset) begin
      if (|sel_q) begin
        data_i = sel_data;
      end else if (hit_v && !hit_regq) begin
        data_i = hit_data;
      end
    end
  end

  // Sticky first-unmapped capture; a new capture beats a simultaneous clear
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (unmapped && (!err_q || err_clr)) begin
      err_d      = 1'b1;
      err_addr_d = address;
    end else if (err_clr) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      act_q      <= '0;
      wr_q       <= 1'b0;
      sel_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      act_q      <= act_d;
      wr_q       <= wr_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign ce       = ce_c;
  assign ch_w     = ch_w_c;
  assign ch_r     = ch_r_c;
  assign ch_d     = data_o;
  assign err      = err_q;
  assign err_addr = err_addr_q;

endmodule

// File: doc/avr_bus_router.md
# avr_bus_router

Parametrised data-bus router between the AVR core data port and up to eight on-chip memory or I/O channels. It replaces the fixed three-window compare-and-mux decode in the board top level with a configurable decoder. Each channel has its own address window, its own wait-state count and an optional registered read-return path. The block drives the core's `ce` to insert wait states and latches the first access that falls outside every window, for debug.

## Interface
Parameters:
- `CHANNELS`, 3: number of channels, 1..8.
- `AW`, 16: address width.
- `DW`, 8: data width.
- `BASE`, {16'h1000,16'h0000,16'hB000}: packed `AW*CHANNELS` window bases; channel k is at bits `[k*AW +: AW]`.
- `SIZE`, {16'h0800,16'h1000,16'h2000}: packed window sizes, nonzero.
- `WAIT`, 0: packed `4*CHANNELS` wait-state counts, 0..15 each.
- `REG_Q`, 0: packed `CHANNELS` bits. 1 selects the read-return mux from the previous cycle's hit (synchronous memory clocked by the core clock). 0 selects it from the current cycle's hit (memory on a faster clock).
- `FILL`, 8'h00: value returned on an unmapped read.

Ports:
- `clock` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `address` in AW: core data address.
- `data_o` in DW: core write data.
- `we` in 1: core write request.
- `read` in 1: core read request.
- `data_i` out DW: read data to the core.
- `ce` out 1: core clock-enable; 0 stalls the core.
- `ch_a` out AW*CHANNELS: per-channel offset, equal to `address - BASE[k]`.
- `ch_d` out DW: write data, broadcast to all channels.
- `ch_w` out CHANNELS: per-channel write strobe.
- `ch_r` out CHANNELS: per-channel read strobe.
- `ch_q` in DW*CHANNELS: per-channel read data.
- `err` out 1: sticky unmapped-access flag.
- `err_addr` out AW: address of the first unmapped access.
- `err_clr` in 1: clears `err` and `err_addr`.

## Operation
- Hit: channel k is hit when `BASE[k] <= address < BASE[k]+SIZE[k]`. The comparison is done in AW+1 bits, so a window ending at 2^AW is legal.
- Overlapping windows: the lowest-index channel wins, so at most one channel is hit.
- Access: an access is `we | read`. A hit with no access asserts no strobes.
- Read strobe: `ch_r[k]` is a level, asserted for every cycle of a read access to k, including wait cycles.
- Write strobe: `ch_w[k]` pulses exactly once per write access, in the completing cycle, i.e. the cycle in which `ce`=1. This makes repeated writes to I/O impossible.
- FSM states are IDLE and WAIT, with a 4-bit counter `cnt`.
  - IDLE, access hits k with `WAIT[k]`=0: `ce`=1, the access completes in this cycle, stay in IDLE.
  - IDLE, access hits k with `WAIT[k]`=W>0: `ce`=0, load `cnt`=W-1, latch k as the active channel, go to WAIT.
  - WAIT, `cnt`≠0: `ce`=0, decrement `cnt`.
  - WAIT, `cnt`=0: `ce`=1, the access completes, go to IDLE. A held access is not re-triggered.
  - Net effect: `ce` is low for exactly W cycles per access.
- Read return: `data_i` = `ch_q[sel]`.
  - `sel` is the current hit if `REG_Q[k]`=0.
  - `sel` is the hit registered in the previous completing cycle if `REG_Q[k]`=1.
  - No hit: `data_i` = `FILL`.
- Unmapped access: an access that hits no channel completes with no wait and no strobes.
  - If `err`=0: set `err`=1 and capture `err_addr`=`address`.
  - If `err`=1: `err_addr` is held, so only the first address is kept.
- Error clear: `err_clr` clears `err` and `err_addr` to 0. If `err_clr` and a new unmapped access occur in the same cycle, set-and-capture wins.
- Simultaneous `we` and `read`: treated as a write. `ch_w` is asserted and `ch_r` is not.

## Timing
- Reset values: state IDLE, `cnt`=0, registered `sel` = none, `err`=0, `err_addr`=0.
- Outputs while `reset`=1: `ce`=0, all `ch_w`/`ch_r` = 0, `data_i`=`FILL`.
- Reset mid-WAIT: the FSM aborts to IDLE on the next edge and no `ch_w` is issued.
- Combinational paths: decode, `ch_a`, `ch_r` and `ce` in IDLE are combinational from `address`/`we`/`read`; there is no added latency for 0-wait channels.
- Write timing: a write completes on the clock edge at which `ce`=1.
- Read timing:
  - `REG_Q`=0: data is valid in the same cycle.
  - `REG_Q`=1: data is valid in the cycle after completion; the core consumes it in that cycle.

## Structure
- Shared package `avr_bus_pkg` holds:
  - the state enum (IDLE, WAIT);
  - the `MAXCH`=8 limit;
  - the `win_t` {base,size} typedef;
  - the default C4 memory map as constants: VRAM B000/2000, CRAM 0000/1000, stack 1000/0800.
- One sub-module, `avr_bus_decode`: a purely combinational priority window decoder producing a one-hot hit vector plus a hit-valid bit. It is instantiated once.

## Test plan
- Default map, 0 wait, `REG_Q`=0: read 0xB123 -> `ch_r`=3'b001, `ch_a[0]`=0x0123, `data_i`=`ch_q[0]` in the same cycle, `ce` stays 1.
- `WAIT[1]`=3, write 0x55 to 0x0010 -> `ce` low for 3 cycles, then a single `ch_w[1]` pulse with `ch_d`=0x55 and `ch_a[1]`=0x0010.
- `REG_Q[2]`=1, read 0x17FF -> `ch_r[2]` asserted, `data_i`=`ch_q[2]` on the next cycle; 0x1800 falls outside the window and counts as unmapped.
- Read 0x9000, then write 0xF000 -> `err`=1, `err_addr`=0x9000, `data_i`=`FILL`; the second unmapped access leaves `err_addr` unchanged. `err_clr` together with a new unmapped access to 0xE000 -> `err`=1, `err_addr`=0xE000.
- Overlap: windows 0000/2000 (ch0) and 1000/1000 (ch1), read 0x1800 -> only ch0 strobed.
- Assert `reset` during the second WAIT cycle of a 3-wait write -> no `ch_w` pulse; after reset release, `ce`=1 and the FSM is in IDLE.
